// File: rtl/seg_scan.sv
// Multiplexed 8-digit seven-segment scanner with blanking dead-time.
// Define SEG_SCAN_SNAPSHOT_EN to latch all patterns once per frame.
module seg_scan #(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] segR0,
  input  logic [7:0] segR1,
  input  logic [7:0] segR2,
  input  logic [7:0] segR3,
  input  logic [7:0] segL0,
  input  logic [7:0] segL1,
  input  logic [7:0] segL2,
  input  logic [7:0] segL3,
  output logic [7:0] seg_out,
  output logic [7:0] dig_sel,
  output logic       frame_tick
);

  localparam int MX = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] DIV_END   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK - 1);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    seg_n, dig_n;
  logic          tick_n;
  logic          enter_show;
  logic [63:0]   live;
  logic [7:0]    pat_enter, pat_show;

  assign live = {segL3, segL2, segL1, segL0,
                 segR3, segR2, segR1, segR0};

  assign enter_show = en && (state == S_BLANK)
                      && (cnt == BLANK_END);

`ifdef SEG_SCAN_SNAPSHOT_EN
  logic [63:0] snap;

  // Digit 0 is loaded straight from the inputs being captured.
  assign pat_enter = (idx == 3'd0) ? live[7:0]
                     : snap[{idx, 3'b000} +: 8];
  assign pat_show  = snap[{idx, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst)
      snap <= '0;
    else if (enter_show && idx == 3'd0)
      snap <= live;
  end
`else
  assign pat_enter = live[{idx, 3'b000} +: 8];
  assign pat_show  = live[{idx, 3'b000} +: 8];
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    seg_n   = '0;
    dig_n   = '0;
    tick_n  = 1'b0;
    if (!en) begin
      state_n = S_BLANK;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        S_BLANK: begin
          if (cnt == BLANK_END) begin
            state_n = S_SHOW;
            cnt_n   = '0;
            dig_n   = 8'b1 << idx;
            seg_n   = pat_enter;
            tick_n  = (idx == 3'd0);
          end
        end
        S_SHOW: begin
          if (cnt == DIV_END) begin
            state_n = S_BLANK;
            cnt_n   = '0;
            idx_n   = idx + 3'd1;
          end else begin
            dig_n = 8'b1 << idx;
            seg_n = pat_show;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_BLANK;
      cnt        <= '0;
      idx        <= '0;
      seg_out    <= '0;
      dig_sel    <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      seg_out    <= seg_n;
      dig_sel    <= dig_n;
      frame_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed and random checks of seg_scan against a
// cycle-position reference model.
module tb_seg_scan;

  localparam int DIV   = 4;
  localparam int BLANK = 2;
  localparam int P     = DIV + BLANK;
`ifdef SEG_SCAN_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] pat [8];
  logic [7:0] seg_out, dig_sel;
  logic       frame_tick;

  logic [7:0] snap [8];
  logic [7:0] e_seg = '0;
  logic [7:0] e_dig = '0;
  logic       e_tick = 1'b0;
  int         t = 0;
  int         checks = 0;
  int         errors = 0;
  bit         armed = 1'b0;
  int         cyc = 0;
  logic [7:0] dig_log [200];
  logic [7:0] seg_log [200];
  int         tq [$];

  seg_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en),
    .segR0(pat[0]), .segR1(pat[1]),
    .segR2(pat[2]), .segR3(pat[3]),
    .segL0(pat[4]), .segL1(pat[5]),
    .segL2(pat[6]), .segL3(pat[7]),
    .seg_out(seg_out), .dig_sel(dig_sel),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Expected outputs of the next cycle from its scan position.
  task automatic model();
    int nt, pos, d;
    bit lit;
    nt  = (rst || !en) ? 0 : t + 1;
    pos = nt % P;
    d   = (nt / P) % 8;
    lit = (pos >= BLANK);
    if (nt % (8 * P) == BLANK) snap = pat;
    e_dig  = lit ? 8'(1 << d) : 8'h00;
    e_seg  = lit ? (SNAP ? snap[d] : pat[d]) : 8'h00;
    e_tick = lit && pos == BLANK && d == 0;
    t = nt;
  endtask

  task automatic tick();
    @(negedge clk);
    if (armed) begin
      checks++;
      assert (dig_sel === e_dig) else begin
        errors++;
        $error("FAIL dig_sel t=%0d got %h exp %h", t, dig_sel, e_dig);
      end
      checks++;
      assert (seg_out === e_seg) else begin
        errors++;
        $error("FAIL seg_out t=%0d got %h exp %h", t, seg_out, e_seg);
      end
      checks++;
      assert (frame_tick === e_tick) else begin
        errors++;
        $error("FAIL frame_tick t=%0d got %b exp %b",
               t, frame_tick, e_tick);
      end
      checks++;
      assert ($onehot0(dig_sel) && (dig_sel != 0 || seg_out == 0))
      else begin
        errors++;
        $error("FAIL onehot got dig %h seg %h exp onehot0/dark",
               dig_sel, seg_out);
      end
    end
    if (cyc >= 0 && cyc < 200) begin
      dig_log[cyc] = dig_sel;
      seg_log[cyc] = seg_out;
    end
    if (frame_tick === 1'b1) tq.push_back(cyc);
    model();
    @(posedge clk);
    #1;
    armed = 1'b1;
    cyc++;
  endtask

  task automatic wait_dig(input logic [7:0] d, input string tag);
    for (int k = 0; k < 200 && dig_sel !== d; k++) tick();
    checks++;
    assert (dig_sel === d) else begin
      errors++;
      $error("FAIL %s timeout got %h exp %h", tag, dig_sel, d);
    end
  endtask

  task automatic set_defaults();
    pat[0] = 8'h3F; pat[1] = 8'h06; pat[2] = 8'h5B; pat[3] = 8'h4F;
    pat[4] = 8'h66; pat[5] = 8'h6D; pat[6] = 8'h7D; pat[7] = 8'h07;
  endtask

  initial begin
    int first;
    set_defaults();
    for (int i = 0; i < 8; i++) snap[i] = 8'h00;
    @(posedge clk);
    #1;
    armed = 1'b1;
    tick();
    checks++;
    assert (seg_out === 8'h00 && dig_sel === 8'h00 && frame_tick === 1'b0)
    else begin
      errors++;
      $error("FAIL reset got %h/%h/%b exp 00/00/0",
             seg_out, dig_sel, frame_tick);
    end

    // scan order and frame_tick over three frames
    rst = 1'b0;
    en  = 1'b1;
    cyc = 0;
    tq.delete();
    repeat (140) tick();
    checks++;
    assert (dig_log[2] === 8'h01 && seg_log[2] === 8'h3F
            && dig_log[5] === 8'h01) else begin
      errors++;
      $error("FAIL digit0 got %h/%h exp 01/3F", dig_log[2], seg_log[2]);
    end
    checks++;
    assert (dig_log[6] === 8'h00 && dig_log[7] === 8'h00
            && seg_log[6] === 8'h00) else begin
      errors++;
      $error("FAIL gap got %h/%h exp 00", dig_log[6], dig_log[7]);
    end
    checks++;
    assert (dig_log[8] === 8'h02 && seg_log[11] === 8'h06) else begin
      errors++;
      $error("FAIL digit1 got %h/%h exp 02/06", dig_log[8], seg_log[11]);
    end
    checks++;
    assert (dig_log[44] === 8'h80 && dig_log[47] === 8'h80
            && dig_log[43] === 8'h00 && dig_log[50] === 8'h01) else begin
      errors++;
      $error("FAIL digit7 got %h/%h exp 80/01", dig_log[44], dig_log[50]);
    end
    checks++;
    assert (tq.size() == 3 && tq[0] == 2 && tq[1] == 50 && tq[2] == 98)
    else begin
      errors++;
      $error("FAIL tick_cycles got n=%0d exp 3 at 2,50,98", tq.size());
    end

    // enable drop during digit 3
    wait_dig(8'h08, "en_wait");
    tick();
    en = 1'b0;
    tick();
    checks++;
    assert (dig_sel === 8'h00 && seg_out === 8'h00) else begin
      errors++;
      $error("FAIL en_drop got %h/%h exp 00/00", dig_sel, seg_out);
    end
    repeat (3) tick();
    en  = 1'b1;
    cyc = 0;
    repeat (10) tick();
    first = -1;
    for (int k = 9; k >= 0; k--)
      if (dig_log[k] === 8'h01) first = k;
    checks++;
    assert (first == BLANK) else begin
      errors++;
      $error("FAIL en_restart got %0d exp %0d", first, BLANK);
    end

    // reset during digit 5
    wait_dig(8'h20, "rst_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    repeat (60) tick();
    checks++;
    assert (dig_log[0] === 8'h00 && dig_log[1] === 8'h00
            && dig_log[2] === 8'h01 && seg_log[2] === 8'h3F
            && dig_log[8] === 8'h02 && dig_log[50] === 8'h01) else begin
      errors++;
      $error("FAIL rst_restart got %h %h %h exp 00 01 02",
             dig_log[0], dig_log[2], dig_log[8]);
    end

    // pattern change mid-frame
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_dig(8'h02, "snap_wait1");
    pat[2] = 8'h4F;
    wait_dig(8'h04, "snap_wait2");
    checks++;
    assert (seg_out === (SNAP ? 8'h5B : 8'h4F)) else begin
      errors++;
      $error("FAIL snap_this got %h exp %h", seg_out,
             SNAP ? 8'h5B : 8'h4F);
    end
    for (int k = 0; k < 20 && dig_sel === 8'h04; k++) tick();
    wait_dig(8'h04, "snap_wait3");
    checks++;
    assert (seg_out === 8'h4F) else begin
      errors++;
      $error("FAIL snap_next got %h exp 4F", seg_out);
    end

    // random en/rst/pattern traffic
    for (int n = 0; n < 20000; n++) begin
      rst = ($urandom % 500 == 0);
      if ($urandom % 400 == 0) en = ~en;
      if ($urandom % 16 == 0) pat[$urandom % 8] = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
